// File: rtl/eth_tx_pkt_buf.sv
// Single-packet TX byte buffer: captures a payload, then replays it to the framer on Tx_Rd_En.
// Optional ETH_TX_PAD_EN pads short packets to MIN_LEN with zero bytes.
module eth_tx_pkt_buf #(
    parameter int DEPTH   = 2048,
    parameter int MIN_LEN = 46
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic [7:0]             Eth_Byte,
    input  logic                   Eth_Byte_Valid,
    input  logic                   Eth_Pkt_Rdy,
    output logic                   Tx_Pkt_Avail,
    output logic [$clog2(DEPTH):0] Tx_Pkt_Len,
    input  logic                   Tx_Rd_En,
    output logic [7:0]             Tx_Byte,
    output logic                   Tx_Byte_Valid,
    output logic                   Tx_Last,
    output logic                   Buf_Busy,
    output logic                   Drop_Err
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int LEN_W  = ADDR_W + 1;

    typedef enum logic [1:0] {IDLE, FILL, READY, DRAIN} state_t;

    state_t             state, state_nxt;
    logic [7:0]         mem [DEPTH];
    logic [LEN_W-1:0]   wr_cnt, rd_cnt, pkt_len, close_len;
    logic               ovf;
    logic               wr_en, rd_issue, drop, close, discard;
    logic               full, last_rd, pad_rd;
    logic [7:0]         rd_data_p1;
    logic               vld_p1, last_p1, zero_p1, drop_p1;

`ifdef ETH_TX_PAD_EN
    function automatic logic [LEN_W-1:0] pad_len(input logic [LEN_W-1:0] n);
        return (n < LEN_W'(MIN_LEN)) ? LEN_W'(MIN_LEN) : n;
    endfunction
    assign pad_rd = (rd_cnt >= wr_cnt);
`else
    function automatic logic [LEN_W-1:0] pad_len(input logic [LEN_W-1:0] n);
        return n;
    endfunction
    assign pad_rd = 1'b0;
`endif

    assign full      = (wr_cnt == LEN_W'(DEPTH));
    assign last_rd   = (rd_cnt == pkt_len - LEN_W'(1));
    assign close_len = wr_cnt + LEN_W'(wr_en);

    always_ff @(posedge Clk) begin
        if (Rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        wr_en     = 1'b0;
        rd_issue  = 1'b0;
        drop      = 1'b0;
        close     = 1'b0;
        discard   = 1'b0;
        case (state)
            IDLE: begin
                // A bare Pkt_Rdy with nothing written is ignored.
                if (Eth_Byte_Valid) begin
                    wr_en     = 1'b1;
                    close     = Eth_Pkt_Rdy;
                    state_nxt = Eth_Pkt_Rdy ? READY : FILL;
                end
            end
            FILL: begin
                if (Eth_Byte_Valid) begin
                    if (full) drop  = 1'b1;
                    else      wr_en = 1'b1;
                end
                if (Eth_Pkt_Rdy) begin
                    if (ovf || drop) begin
                        discard   = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        close     = 1'b1;
                        state_nxt = READY;
                    end
                end
            end
            READY: begin
                drop = Eth_Byte_Valid;
                if (Tx_Rd_En) begin
                    rd_issue  = 1'b1;
                    state_nxt = last_rd ? IDLE : DRAIN;
                end
            end
            DRAIN: begin
                drop = Eth_Byte_Valid;
                if (Tx_Rd_En && (rd_cnt < pkt_len)) begin
                    rd_issue = 1'b1;
                    if (last_rd) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            wr_cnt  <= '0;
            rd_cnt  <= '0;
            pkt_len <= '0;
            ovf     <= 1'b0;
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
            zero_p1 <= 1'b1;
            drop_p1 <= 1'b0;
        end else begin
            vld_p1  <= rd_issue;
            last_p1 <= rd_issue && last_rd;
            drop_p1 <= drop;
            if (wr_en) wr_cnt <= wr_cnt + LEN_W'(1);
            if (drop && (state == FILL)) ovf <= 1'b1;
            if (close) pkt_len <= pad_len(close_len);
            if (rd_issue) begin
                rd_cnt  <= rd_cnt + LEN_W'(1);
                zero_p1 <= pad_rd;
            end
            // Packet finished or discarded: the buffer restarts at mem[0].
            if (discard || (rd_issue && last_rd)) begin
                wr_cnt <= '0;
                rd_cnt <= '0;
                ovf    <= 1'b0;
            end
        end
    end

    // Storage stage: plain write port and registered read, no reset, so it maps to block RAM.
    always_ff @(posedge Clk) begin
        if (wr_en)    mem[wr_cnt[ADDR_W-1:0]] <= Eth_Byte;
        if (rd_issue) rd_data_p1 <= mem[rd_cnt[ADDR_W-1:0]];
    end

    assign Tx_Byte       = zero_p1 ? 8'h00 : rd_data_p1;
    assign Tx_Byte_Valid = vld_p1;
    assign Tx_Last       = last_p1;
    assign Tx_Pkt_Len    = pkt_len;
    assign Tx_Pkt_Avail  = (state == READY) || (state == DRAIN);
    assign Buf_Busy      = Tx_Pkt_Avail;
    assign Drop_Err      = drop_p1;
endmodule

// File: tb/tb_eth_tx_pkt_buf.sv
// Scoreboard bench for eth_tx_pkt_buf; expectations follow ETH_TX_PAD_EN when it is defined.
module tb_eth_tx_pkt_buf;
    localparam int DEPTH   = 128;
    localparam int MIN_LEN = 46;
    localparam int LEN_W   = $clog2(DEPTH) + 1;

    logic             Clk = 1'b0;
    logic             Rst;
    logic [7:0]       Eth_Byte;
    logic             Eth_Byte_Valid, Eth_Pkt_Rdy, Tx_Rd_En;
    logic             Tx_Pkt_Avail, Tx_Byte_Valid, Tx_Last, Buf_Busy, Drop_Err;
    logic [LEN_W-1:0] Tx_Pkt_Len;
    logic [7:0]       Tx_Byte;

    always #5 Clk = ~Clk;

    eth_tx_pkt_buf #(.DEPTH(DEPTH), .MIN_LEN(MIN_LEN)) dut (
        .Clk(Clk), .Rst(Rst),
        .Eth_Byte(Eth_Byte), .Eth_Byte_Valid(Eth_Byte_Valid), .Eth_Pkt_Rdy(Eth_Pkt_Rdy),
        .Tx_Pkt_Avail(Tx_Pkt_Avail), .Tx_Pkt_Len(Tx_Pkt_Len), .Tx_Rd_En(Tx_Rd_En),
        .Tx_Byte(Tx_Byte), .Tx_Byte_Valid(Tx_Byte_Valid), .Tx_Last(Tx_Last),
        .Buf_Busy(Buf_Busy), .Drop_Err(Drop_Err)
    );

    typedef struct packed {logic [7:0] b; logic last;} exp_t;
    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   drops = 0;
    logic rd_prev = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int exp_len(input int n);
`ifdef ETH_TX_PAD_EN
        return (n < MIN_LEN) ? MIN_LEN : n;
`else
        return n;
`endif
    endfunction

    always @(posedge Clk) rd_prev <= Tx_Rd_En;

    // Monitor: pops the scoreboard whenever the DUT presents a byte.
    always @(negedge Clk) begin
        exp_t e;
        if (Drop_Err) drops++;
        if (Tx_Byte_Valid) begin
            check("valid_after_rd_en", int'(rd_prev), 1);
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL extra_byte: got %0d expected no output", Tx_Byte);
            end else begin
                e = sb.pop_front();
                check("tx_byte", int'(Tx_Byte), int'(e.b));
                check("tx_last", int'(Tx_Last), int'(e.last));
                if (e.last) check("avail_drop_at_last", int'(Tx_Pkt_Avail), 0);
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic send_pkt(input int n, input int start, input bit rdy_with_last);
        for (int i = 0; i < n; i++) begin
            Eth_Byte       = 8'(start + i);
            Eth_Byte_Valid = 1'b1;
            Eth_Pkt_Rdy    = rdy_with_last && (i == n - 1);
            tick();
        end
        Eth_Byte_Valid = 1'b0;
        if (!rdy_with_last) begin
            Eth_Pkt_Rdy = 1'b1;
            tick();
        end
        Eth_Pkt_Rdy = 1'b0;
    endtask

    // pat 0: Rd_En held high; pat 1: 1-0-0-1 pattern. inject: busy-write bytes sent at read start.
    task automatic read_pkt(input int n, input int start, input int pat, input int inject);
        int len, issued, cyc;
        bit en;
        exp_t e;
        len = exp_len(n);
        check("pkt_avail", int'(Tx_Pkt_Avail), 1);
        check("pkt_len", int'(Tx_Pkt_Len), len);
        issued = 0;
        cyc = 0;
        while (issued < len && cyc < 4000) begin
            en = (pat == 0) ? 1'b1 : ((cyc % 3) == 0);
            Tx_Rd_En       = en;
            Eth_Byte_Valid = (cyc < inject);
            Eth_Byte       = 8'hEE;
            if (en) begin
                e.b    = (issued < n) ? 8'(start + issued) : 8'h00;
                e.last = (issued == len - 1);
                sb.push_back(e);
                issued++;
            end
            tick();
            cyc++;
        end
        check("read_issued", issued, len);
        Tx_Rd_En       = 1'b0;
        Eth_Byte_Valid = 1'b0;
        tick();
        tick();
        check("sb_drained", sb.size(), 0);
        check("avail_after_drain", int'(Tx_Pkt_Avail), 0);
        check("busy_after_drain", int'(Buf_Busy), 0);
    endtask

    initial begin
        exp_t e;
        Rst = 1'b1; Eth_Byte = 8'h00; Eth_Byte_Valid = 1'b0; Eth_Pkt_Rdy = 1'b0; Tx_Rd_En = 1'b0;
        repeat (3) tick();
        check("rst_avail", int'(Tx_Pkt_Avail), 0);
        check("rst_valid", int'(Tx_Byte_Valid), 0);
        check("rst_last", int'(Tx_Last), 0);
        check("rst_busy", int'(Buf_Busy), 0);
        check("rst_drop", int'(Drop_Err), 0);
        check("rst_byte", int'(Tx_Byte), 0);
        check("rst_len", int'(Tx_Pkt_Len), 0);
        Rst = 1'b0;
        tick();

        // Pkt_Rdy with nothing written is ignored.
        Eth_Pkt_Rdy = 1'b1; tick(); Eth_Pkt_Rdy = 1'b0; tick();
        check("idle_rdy_avail", int'(Tx_Pkt_Avail), 0);

        send_pkt(100, 1, 1'b0);
        read_pkt(100, 1, 0, 0);
        send_pkt(100, 1, 1'b0);
        read_pkt(100, 1, 1, 0);

        drops = 0;
        send_pkt(5, 8'h50, 1'b0);
        read_pkt(5, 8'h50, 1, 3);
        check("busy_drops", drops, 3);
        send_pkt(4, 8'hA0, 1'b1);
        read_pkt(4, 8'hA0, 0, 0);
        send_pkt(1, 8'h77, 1'b1);
        read_pkt(1, 8'h77, 0, 0);

        drops = 0;
        send_pkt(DEPTH + 6, 0, 1'b0);
        tick();
        check("ovf_drops", drops, 6);
        check("ovf_avail", int'(Tx_Pkt_Avail), 0);
        check("ovf_busy", int'(Buf_Busy), 0);
        send_pkt(10, 8'h30, 1'b0);
        read_pkt(10, 8'h30, 0, 0);

        // Reset in the middle of a drain.
        send_pkt(100, 1, 1'b0);
        for (int i = 0; i < 40; i++) begin
            Tx_Rd_En = 1'b1;
            e.b = 8'(1 + i);
            e.last = 1'b0;
            sb.push_back(e);
            tick();
        end
        Rst = 1'b1;
        tick();
        check("mid_rst_avail", int'(Tx_Pkt_Avail), 0);
        check("mid_rst_valid", int'(Tx_Byte_Valid), 0);
        check("mid_rst_byte", int'(Tx_Byte), 0);
        check("mid_rst_busy", int'(Buf_Busy), 0);
        Rst = 1'b0;
        repeat (5) tick();
        Tx_Rd_En = 1'b0;
        tick();
        check("mid_rst_sb", sb.size(), 0);
        send_pkt(10, 8'hC0, 1'b0);
        read_pkt(10, 8'hC0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end
endmodule
